// File: rtl/led_pattern_sequencer.sv
// LED bar pattern sequencer: four display modes at four step rates,
// stepped by two debounced push-buttons (mode, speed).
module led_pattern_sequencer #(
  parameter int TICK_CYCLES     = 3_375_000,
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_mode_n,
  input  logic       btn_speed_n,
  output logic [5:0] led,
  output logic       red_led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       tick
);

  localparam int BW = $clog2(TICK_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  // index 0: mode button, index 1: speed button
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         stable_q, stable_d;
  logic [1:0]         press_q, press_d;
  logic [1:0][DW-1:0] deb_q, deb_d;

  logic [BW-1:0] base_q, base_d;
  logic [2:0]    div_q, div_d;
  mode_e         mode_q, mode_d;
  logic [1:0]    speed_q, speed_d;
  logic [2:0]    pos_q, pos_d;
  logic          dir_q, dir_d;
  logic          phase_q, phase_d;
  logic          red_q, red_d;
  logic          tick_q, tick_d;
  logic [5:0]    led_q, led_d;
  logic          wrap;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      press_d[i]  = 1'b0;
      deb_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = stable_q[i];
        end else begin
          deb_d[i] = deb_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    base_d  = base_q;
    div_d   = div_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    red_d   = red_q;
    wrap    = 1'b0;

    if (|press_q) begin
      base_d = '0;
      div_d  = '0;
    end else if (base_q == BW'(TICK_CYCLES - 1)) begin
      base_d = '0;
      div_d  = (div_q >= (3'b111 >> speed_q)) ? 3'd0 : div_q + 3'd1;
    end else begin
      base_d = base_q + BW'(1);
    end

    if (tick_q) begin
      unique case (mode_q)
        ROT_L: begin
          wrap  = (pos_q == 3'd5);
          pos_d = wrap ? 3'd0 : pos_q + 3'd1;
        end
        ROT_R: begin
          wrap  = (pos_q == 3'd0);
          pos_d = wrap ? 3'd5 : pos_q - 3'd1;
        end
        BOUNCE: begin
          if (!dir_q) begin
            wrap  = (pos_q == 3'd5);
            dir_d = wrap;
            pos_d = wrap ? 3'd4 : pos_q + 3'd1;
          end else begin
            wrap  = (pos_q == 3'd0);
            dir_d = !wrap;
            pos_d = wrap ? 3'd1 : pos_q - 3'd1;
          end
        end
        BLINK: begin
          phase_d = !phase_q;
          wrap    = !phase_q;
        end
      endcase
      red_d = wrap;
    end

    if (press_q[0]) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      pos_d   = '0;
      dir_d   = 1'b0;
      phase_d = 1'b0;
      red_d   = 1'b0;
    end
    if (press_q[1]) speed_d = speed_q + 2'd1;

    // registered tick lines up with the terminal count it describes
    tick_d = !(|press_d)
           && (base_d == BW'(TICK_CYCLES - 1))
           && (div_d == (3'b111 >> speed_d));

    if (mode_d == BLINK) led_d = phase_d ? 6'b000000 : 6'b111111;
    else                 led_d = ~(6'b000001 << pos_d);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      press_q  <= '0;
      deb_q    <= '0;
      base_q   <= '0;
      div_q    <= '0;
      mode_q   <= ROT_L;
      speed_q  <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      phase_q  <= 1'b0;
      red_q    <= 1'b0;
      tick_q   <= 1'b0;
      led_q    <= 6'b111110;
    end else begin
      sync1_q  <= {btn_speed_n, btn_mode_n};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      deb_q    <= deb_d;
      base_q   <= base_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      phase_q  <= phase_d;
      red_q    <= red_d;
      tick_q   <= tick_d;
      led_q    <= led_d;
    end
  end

  assign led     = led_q;
  assign red_led = red_q;
  assign mode    = mode_q;
  assign speed   = speed_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: random button activity and resets
// checked every cycle against a behavioural model.
module tb_led_pattern_sequencer;

  localparam int TICK = 4;
  localparam int DEB  = 3;

  logic       clk = 1'b0;
  logic       rst, bm, bs;
  logic [5:0] led;
  logic       red, tick;
  logic [1:0] mode, speed;

  led_pattern_sequencer #(
    .TICK_CYCLES(TICK),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .btn_mode_n(bm),
    .btn_speed_n(bs),
    .led(led),
    .red_led(red),
    .mode(mode),
    .speed(speed),
    .tick(tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mode, m_speed, m_pos, m_phase, m_b, m_red, m_tick, m_age;
  bit m_desc;
  int s1[2], s2[2], stab[2], run[2];
  bit ev[2];

  int hold[2];
  bit lvl[2];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int interval(input int sp);
    return TICK * (8 >> sp);
  endfunction

  function automatic int exp_led();
    logic [5:0] one;
    logic [5:0] v;
    one = 6'd1;
    if (m_mode == 3) v = m_phase ? 6'h00 : 6'h3f;
    else             v = ~(one << m_pos);
    return int'(v);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_speed = 0; m_pos = 0; m_phase = 0;
    m_b = 0; m_desc = 0; m_red = 0; m_tick = 0; m_age = 0;
    for (int i = 0; i < 2; i++) begin
      s1[i] = 1; s2[i] = 1; stab[i] = 1; run[i] = 0; ev[i] = 0;
    end
  endtask

  // advances the model across one clock edge with the sampled inputs
  task automatic m_step(input bit r, input bit raw_m, input bit raw_s);
    bit nev[2];
    int wrap;
    int raw[2];
    if (r) begin
      m_reset();
      return;
    end
    raw[0] = raw_m;
    raw[1] = raw_s;
    if (m_tick != 0) begin
      wrap = 0;
      case (m_mode)
        0: begin m_pos = (m_pos + 1) % 6; wrap = (m_pos == 0); end
        1: begin m_pos = (m_pos + 5) % 6; wrap = (m_pos == 5); end
        2: begin
          wrap = (m_b == 5) || (m_b == 0 && m_desc);
          if (m_b == 9) m_desc = 1;
          m_b = (m_b + 1) % 10;
          m_pos = (m_b <= 5) ? m_b : 10 - m_b;
        end
        default: begin m_phase ^= 1; wrap = m_phase; end
      endcase
      m_red = wrap;
    end
    if (ev[0]) begin
      m_mode = (m_mode + 1) % 4;
      m_pos = 0; m_b = 0; m_desc = 0; m_phase = 0; m_red = 0;
    end
    if (ev[1]) m_speed = (m_speed + 1) % 4;
    if (ev[0] || ev[1] || m_tick != 0) m_age = 0;
    else m_age++;
    for (int i = 0; i < 2; i++) begin
      nev[i] = 0;
      if (s2[i] != stab[i]) begin
        run[i]++;
        if (run[i] == DEB) begin
          stab[i] = s2[i];
          run[i] = 0;
          nev[i] = (s2[i] == 0);
        end
      end else begin
        run[i] = 0;
      end
      s2[i] = s1[i];
      s1[i] = raw[i];
    end
    ev = nev;
    m_tick = (m_age == interval(m_speed) - 1) && !ev[0] && !ev[1];
  endtask

  task automatic drive(input int c);
    rst = 1'b0;
    if (c < 300) begin
      bm = 1'b1; bs = 1'b1;
    end else if (c < 310) begin
      bm = 1'b0; bs = 1'b0;
    end else if (c < 400) begin
      bm = 1'b1; bs = 1'b1;
    end else if (c == 3000 || $urandom_range(0, 399) == 0) begin
      rst = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          lvl[i] = ~lvl[i];
          if ($urandom_range(0, 3) == 0) hold[i] = $urandom_range(1, 2);
          else hold[i] = $urandom_range(4, 150);
        end
        hold[i]--;
      end
      bm = lvl[0];
      bs = lvl[1];
    end
  endtask

  initial begin
    rst = 1'b1; bm = 1'b1; bs = 1'b1;
    lvl[0] = 1; lvl[1] = 1; hold[0] = 0; hold[1] = 0;
    m_reset();
    repeat (2) @(posedge clk);
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      check("led",   int'(led),   exp_led());
      check("red",   int'(red),   m_red);
      check("mode",  int'(mode),  m_mode);
      check("speed", int'(speed), m_speed);
      check("tick",  int'(tick),  m_tick);
      drive(c);
      m_step(rst, bm, bs);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
